// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: bit indices, channel count, timing defaults
// and the counter-width helper.
package btn_pkg;

    localparam int unsigned BTN_UP        = 0;
    localparam int unsigned BTN_DOWN      = 1;
    localparam int unsigned BTN_SLIDE     = 2;
    localparam int unsigned BTN_PLACE     = 3;
    localparam int unsigned BTN_PW_SET    = 4;
    localparam int unsigned BTN_PW_ENDSET = 5;
    localparam int unsigned BTN_OK        = 6;
    localparam int unsigned BTN_N         = 7;

    localparam int unsigned DB_CYCLES_DEF  = 252000;
    localparam int unsigned RPT_DELAY_DEF  = 12600000;
    localparam int unsigned RPT_PERIOD_DEF = 2520000;

    // Width that holds the largest of the three counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-cycle counter, debounced level and a
// single-cycle pulse on each rising level.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DbLast) begin
            // This edge is the DB_CYCLES-th consecutive differing sample.
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// Seven-channel button conditioner: per-channel debounce plus optional auto-repeat on up/down,
// compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BTN_N-1:0] btn_raw,
    output logic [BTN_N-1:0] btn_level,
    output logic [BTN_N-1:0] btn_pulse
);

    localparam int unsigned CntW = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);

    logic [BTN_N-1:0] deb_level;
    logic [BTN_N-1:0] deb_pulse;

    for (genvar i = 0; i < BTN_N; i++) begin : g_chan
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CntW)
        ) u_debounce (
            .clk_i  (clk),
            .rst_ni (rst),
            .raw_i  (btn_raw[i]),
            .level_o(deb_level[i]),
            .pulse_o(deb_pulse[i])
        );
    end

    assign btn_level = deb_level;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned      RptN       = 2;
    localparam logic [CntW-1:0]  RptDelayC  = CntW'(RPT_DELAY);
    localparam logic [CntW-1:0]  RptPeriodC = CntW'(RPT_PERIOD);

    logic [RptN-1:0][CntW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RptN-1:0]           rpt_armed_q, rpt_armed_d;
    logic [RptN-1:0]           rpt_fire_q, rpt_fire_d;
    logic [RptN-1:0]           rpt_level;
    logic [BTN_N-1:0]          rpt_pulse;

    assign rpt_level = {deb_level[BTN_DOWN], deb_level[BTN_UP]};

    // First target is RPT_DELAY after the press, then RPT_PERIOD between repeats.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_armed_d = rpt_armed_q;
        rpt_fire_d  = '0;
        for (int i = 0; i < RptN; i++) begin
            if (!rpt_level[i]) begin
                rpt_cnt_d[i]   = '0;
                rpt_armed_d[i] = 1'b0;
            end else if (CntW'(rpt_cnt_q[i] + 1'b1) ==
                         (rpt_armed_q[i] ? RptPeriodC : RptDelayC)) begin
                rpt_cnt_d[i]   = '0;
                rpt_armed_d[i] = 1'b1;
                rpt_fire_d[i]  = 1'b1;
            end else begin
                rpt_cnt_d[i] = CntW'(rpt_cnt_q[i] + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= '0;
            rpt_fire_q  <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
            rpt_fire_q  <= rpt_fire_d;
        end
    end

    // Masking with the live level drops a repeat that coincides with the release edge.
    always_comb begin
        rpt_pulse           = '0;
        rpt_pulse[BTN_UP]   = rpt_fire_q[0] & rpt_level[0];
        rpt_pulse[BTN_DOWN] = rpt_fire_q[1] & rpt_level[1];
    end

    assign btn_pulse = deb_pulse | rpt_pulse;
`else
    assign btn_pulse = deb_pulse;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized stimulus against
// a window-based reference model.
module tb_btn_conditioner;

    localparam int unsigned TB_DB = 4;
    localparam int unsigned TB_RD = 20;
    localparam int unsigned TB_RP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] btn_raw = 7'h00;
    logic [6:0] btn_level;
    logic [6:0] btn_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [6:0] m_p1, m_p2, m_level, m_pulse;
    logic [6:0] m_win [TB_DB];
    int         m_cyc = 0;
    int         m_press [2];

    always #5 clk = ~clk;

    btn_conditioner #(
        .DB_CYCLES (TB_DB),
        .RPT_DELAY (TB_RD),
        .RPT_PERIOD(TB_RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Level flips once the last DB_CYCLES synchronized samples all disagree with it.
    task automatic model_edge(input logic r, input logic [6:0] raw);
        logic [6:0] nl;
        bit         all_diff;
        int         d;
        m_cyc++;
        if (!r) begin
            m_p1 = '0;
            m_p2 = '0;
            for (int j = 0; j < TB_DB; j++) m_win[j] = '0;
            m_level = '0;
            m_pulse = '0;
        end else begin
            for (int j = 0; j < TB_DB - 1; j++) m_win[j] = m_win[j+1];
            m_win[TB_DB-1] = m_p2;
            nl = m_level;
            for (int b = 0; b < 7; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < TB_DB; j++) if (m_win[j][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) nl[b] = ~m_level[b];
            end
            m_pulse = nl & ~m_level;
            for (int b = 0; b < 2; b++) if (m_pulse[b]) m_press[b] = m_cyc;
`ifdef BTN_AUTOREPEAT_EN
            for (int b = 0; b < 2; b++) begin
                if (nl[b] && m_level[b]) begin
                    d = m_cyc - m_press[b];
                    if (d == TB_RD || (d > TB_RD && (d - TB_RD) % TB_RP == 0)) m_pulse[b] = 1'b1;
                end
            end
`endif
            m_p2    = m_p1;
            m_p1    = raw;
            m_level = nl;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, btn_raw);
        #1;
        check_eq("level", {25'd0, btn_level}, {25'd0, m_level});
        check_eq("pulse", {25'd0, btn_pulse}, {25'd0, m_pulse});
    endtask

    // Steps until bit b of pulse/level equals want; lat is the 1-based edge count or -1.
    task automatic wait_for(input int b, input bit on_pulse, input logic want,
                            output int lat, output int npulse);
        lat    = -1;
        npulse = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (btn_pulse[b]) npulse++;
            if ((on_pulse ? btn_pulse[b] : btn_level[b]) == want) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, finish required");
        $fatal(1);
    end

    initial begin
        int lat, np, seen, idx;
        int pq[$];
        int exp_off[$];

        // Reset held with every button pressed
        rst     = 1'b0;
        btn_raw = 7'h7F;
        repeat (3) begin
            step();
            check_eq("rst_level", {25'd0, btn_level}, 32'd0);
            check_eq("rst_pulse", {25'd0, btn_pulse}, 32'd0);
        end
        rst = 1'b1;
        wait_for(6, 1'b0, 1'b1, lat, np);
        check_eq("rst_rise_lat", lat, TB_DB + 2);
        check_eq("rst_rise_pulse", {25'd0, btn_pulse}, 32'h7F);
        step();
        check_eq("rst_pulse_once", {25'd0, btn_pulse}, 32'd0);
        btn_raw = 7'h00;
        repeat (12) step();
        check_eq("all_released", {25'd0, btn_level}, 32'd0);

        // Glitch on slide shorter than the debounce window
        seen = 0;
        btn_raw[2] = 1'b1;
        repeat (3) begin
            step();
            if (btn_level[2] || btn_pulse[2]) seen = 1;
        end
        btn_raw[2] = 1'b0;
        repeat (15) begin
            step();
            if (btn_level[2] || btn_pulse[2]) seen = 1;
        end
        check_eq("glitch", seen, 0);

        // Clean press and release on OK
        btn_raw[6] = 1'b1;
        wait_for(6, 1'b1, 1'b1, lat, np);
        check_eq("press_lat", lat, TB_DB + 2);
        np = 0;
        repeat (10) begin
            step();
            if (btn_pulse[6]) np++;
        end
        check_eq("press_single", np, 0);
        check_eq("press_level", {31'd0, btn_level[6]}, 32'd1);
        btn_raw[6] = 1'b0;
        wait_for(6, 1'b0, 1'b0, lat, np);
        check_eq("release_lat", lat, TB_DB + 2);
        check_eq("release_no_pulse", np, 0);
        repeat (4) step();

        // Simultaneous place + PW_set
        btn_raw = 7'h18;
        wait_for(3, 1'b1, 1'b1, lat, np);
        check_eq("simul_lat", lat, TB_DB + 2);
        check_eq("simul_pulse", {25'd0, btn_pulse}, 32'h18);
        check_eq("simul_level", {25'd0, btn_level}, 32'h18);
        btn_raw = 7'h00;
        repeat (12) step();

        // Up held for 50 cycles: level stays high for 50 edges after the press
        exp_off.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = TB_RD; k < 50; k += TB_RP) exp_off.push_back(k);
`endif
        btn_raw = 7'h01;
        for (int i = 0; i < 65; i++) begin
            if (i == 50) btn_raw = 7'h00;
            step();
            if (btn_pulse[0]) pq.push_back(i);
        end
        check_eq("rpt_count", pq.size(), exp_off.size());
        for (int k = 0; k < pq.size() && k < exp_off.size(); k++)
            check_eq("rpt_offset", pq[k] - pq[0], exp_off[k]);

        // Reset mid-repeat (down) and mid-debounce (PW_endset), held through release
        btn_raw = 7'h02;
        repeat (30) step();
        btn_raw = 7'h22;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) begin
            step();
            check_eq("mid_rst_pulse", {25'd0, btn_pulse}, 32'd0);
        end
        rst = 1'b1;
        wait_for(1, 1'b1, 1'b1, lat, np);
        check_eq("rehold_lat", lat, TB_DB + 2);
        check_eq("rehold_pulse", {25'd0, btn_pulse}, 32'h22);
        btn_raw = 7'h00;
        repeat (12) step();

        // Randomized toggles with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 6);
                btn_raw[idx] = ~btn_raw[idx];
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
